// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the DRAM sequencer between CPU, DMA and refresh.
// Define DRAM_ARB_DMA_EN to enable the DMA port and CPU/DMA round-robin.
module dram_arbiter #(
   parameter int REFRESH_INTERVAL = 20,
   parameter int MAX_PENDING      = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CPU_REQ,
   input  logic [21:0] CPU_ADDR,
   output logic        DTACK_DRAM,
   input  logic        DMA_REQ,
   input  logic [21:0] DMA_ADDR,
   output logic        DMA_ACK,
   output logic        SEQ_REQ,
   output logic        SEQ_REFRESH,
   output logic [21:0] SEQ_ADDR,
   input  logic        SEQ_ACK
);

   typedef enum logic [2:0] {
      IDLE,
      CPU_ACC,
      CPU_HOLD,
      DMA_ACC,
      REF_ACC
   } state_t;

   localparam logic [11:0] TICK_LAST = 12'(REFRESH_INTERVAL - 1);
   localparam logic [2:0]  PEND_MAX  = 3'(MAX_PENDING);

   state_t      state;
   logic [11:0] tick;
   logic [2:0]  pending;
   logic        last_cpu;
   logic        cpu_served;

   logic wrap;
   logic urgent;
   logic ref_done;
   logic cpu_elig;
   logic dma_elig;
   logic cpu_win;
   logic dma_win;

   assign wrap     = (tick == TICK_LAST);
   assign urgent   = (pending == PEND_MAX);
   assign ref_done = (state == REF_ACC) && SEQ_ACK;
   assign cpu_elig = CPU_REQ && !cpu_served;

`ifdef DRAM_ARB_DMA_EN
   assign dma_elig = DMA_REQ;
`else
   logic unused_dma;
   assign unused_dma = ^{DMA_REQ, DMA_ADDR};
   assign dma_elig   = 1'b0;
`endif

   // on a CPU/DMA tie the master not served last wins
   assign cpu_win = cpu_elig && (!dma_elig || !last_cpu);
   assign dma_win = dma_elig && !cpu_win;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         tick    <= '0;
         pending <= '0;
      end else begin
         tick <= wrap ? '0 : tick + 12'd1;
         if (wrap && !ref_done) begin
            if (!urgent)
               pending <= pending + 3'd1;
         end else if (ref_done && !wrap) begin
            pending <= pending - 3'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= IDLE;
         last_cpu    <= 1'b0;
         cpu_served  <= 1'b0;
         SEQ_REQ     <= 1'b0;
         SEQ_REFRESH <= 1'b0;
         SEQ_ADDR    <= '0;
         DTACK_DRAM  <= 1'b1;
         DMA_ACK     <= 1'b0;
      end else begin
         DMA_ACK <= 1'b0;
         if (!CPU_REQ)
            cpu_served <= 1'b0;
         unique case (state)
            IDLE: begin
               if (urgent) begin
                  state       <= REF_ACC;
                  SEQ_REQ     <= 1'b1;
                  SEQ_REFRESH <= 1'b1;
                  SEQ_ADDR    <= '0;
               end else if (cpu_win) begin
                  state       <= CPU_ACC;
                  SEQ_REQ     <= 1'b1;
                  SEQ_REFRESH <= 1'b0;
                  SEQ_ADDR    <= CPU_ADDR;
                  last_cpu    <= 1'b1;
               end else if (dma_win) begin
                  state       <= DMA_ACC;
                  SEQ_REQ     <= 1'b1;
                  SEQ_REFRESH <= 1'b0;
                  SEQ_ADDR    <= DMA_ADDR;
                  last_cpu    <= 1'b0;
               end else if (pending != 3'd0) begin
                  state       <= REF_ACC;
                  SEQ_REQ     <= 1'b1;
                  SEQ_REFRESH <= 1'b1;
                  SEQ_ADDR    <= '0;
               end
            end
            CPU_ACC: begin
               if (SEQ_ACK) begin
                  SEQ_REQ  <= 1'b0;
                  SEQ_ADDR <= '0;
                  // an aborted bus cycle finishes silently
                  if (CPU_REQ) begin
                     state      <= CPU_HOLD;
                     DTACK_DRAM <= 1'b0;
                     cpu_served <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            CPU_HOLD: begin
               if (!CPU_REQ) begin
                  state      <= IDLE;
                  DTACK_DRAM <= 1'b1;
               end
            end
            DMA_ACC: begin
               if (SEQ_ACK) begin
                  state    <= IDLE;
                  SEQ_REQ  <= 1'b0;
                  SEQ_ADDR <= '0;
                  DMA_ACK  <= 1'b1;
               end
            end
            REF_ACC: begin
               if (SEQ_ACK) begin
                  state       <= IDLE;
                  SEQ_REQ     <= 1'b0;
                  SEQ_REFRESH <= 1'b0;
                  SEQ_ADDR    <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
